// File: rtl/inst_load_ctrl_pkg.sv
// Shared constants and types for the instruction-load controller.
// The SUM state exists only when INST_LOAD_CHECKSUM_EN is defined.
package inst_load_ctrl_pkg;

    localparam int INST_SIZE = 14;

    localparam logic [2:0] MODE_STALL = 3'd0;
    localparam logic [2:0] MODE_LOAD  = 3'd1;
    localparam logic [2:0] MODE_EXEC  = 3'd2;

    localparam logic [7:0] ACK_BYTE = 8'hAA;
    localparam logic [7:0] NAK_BYTE = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
`ifdef INST_LOAD_CHECKSUM_EN
        ST_SUM,
`endif
        ST_ACK,
        ST_RUN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/inst_load_ctrl_if.sv
// Bundle of UART, BRAM and status signals around inst_load_ctrl.
// Handshake: a tx byte moves on a cycle where tx_valid && tx_ready; rx_valid is an unacknowledged one-cycle pulse.
interface inst_load_ctrl_if #(parameter int INST_SIZE = inst_load_ctrl_pkg::INST_SIZE);
    import inst_load_ctrl_pkg::*;

    logic                 start;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 tx_ready;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic [INST_SIZE-1:0] bram_addr;
    logic [31:0]          bram_din;
    logic                 bram_we;
    logic [2:0]           mode;
    logic [INST_SIZE:0]   word_count;
    logic                 done;
    logic                 err;
    state_t               state;

    modport master (
        output start, rx_valid, rx_data, tx_ready,
        input  tx_valid, tx_data, bram_addr, bram_din, bram_we,
               mode, word_count, done, err, state
    );

    modport slave (
        input  start, rx_valid, rx_data, tx_ready,
        output tx_valid, tx_data, bram_addr, bram_din, bram_we,
               mode, word_count, done, err, state
    );

endinterface

// File: rtl/inst_load_ctrl_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; word_valid fires
// combinationally on the cycle the 4th byte arrives.
module inst_load_ctrl_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (in_valid) begin
            shift_d = {in_byte, shift_q[23:8]};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // Earlier bytes sit in the low lanes, so the new byte completes the top one.
    assign word       = {in_byte, shift_q};
    assign word_valid = in_valid && !clear && (cnt_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/inst_load_ctrl.sv
// Program loader: UART header + words into instruction BRAM, then ACK/NAK and run mode.
// Optional trailer checksum enabled by INST_LOAD_CHECKSUM_EN.
module inst_load_ctrl #(
    parameter int INST_SIZE = inst_load_ctrl_pkg::INST_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    inst_load_ctrl_if.slave  bus
);
    import inst_load_ctrl_pkg::*;

    localparam logic [32:0] CAP = 33'd1 << INST_SIZE;

    state_t               state_q, state_d;
    logic [INST_SIZE:0]   word_count_q, word_count_d;
    logic [INST_SIZE:0]   len_q, len_d;
    logic                 bram_we_q, bram_we_d;
    logic [INST_SIZE-1:0] bram_addr_q, bram_addr_d;
    logic [31:0]          bram_din_q, bram_din_d;
    logic                 nak_sent_q, nak_sent_d;
`ifdef INST_LOAD_CHECKSUM_EN
    logic [31:0]          sum_q, sum_d;
`endif

    logic        pk_clear, pk_valid, pk_word_valid;
    logic [31:0] pk_word;
    logic        restart;
    logic        last_word;

    assign restart   = bus.start && (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_ERR);
    assign last_word = (word_count_q + 1'b1) == len_q;
    assign pk_clear  = restart;
    assign pk_valid  = bus.rx_valid &&
                       (state_q == ST_HDR || state_q == ST_BODY
`ifdef INST_LOAD_CHECKSUM_EN
                        || state_q == ST_SUM
`endif
                       );

    inst_load_ctrl_byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .in_valid   (pk_valid),
        .in_byte    (bus.rx_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_HDR;
            ST_HDR: if (pk_word_valid) begin
`ifdef INST_LOAD_CHECKSUM_EN
                if (pk_word == '0)                 state_d = ST_SUM;
`else
                if (pk_word == '0)                 state_d = ST_ACK;
`endif
                else if ({1'b0, pk_word} > CAP)    state_d = ST_ERR;
                else                               state_d = ST_BODY;
            end
`ifdef INST_LOAD_CHECKSUM_EN
            ST_BODY: if (pk_word_valid && last_word) state_d = ST_SUM;
            ST_SUM:  if (pk_word_valid) state_d = (pk_word == sum_q) ? ST_ACK : ST_ERR;
`else
            ST_BODY: if (pk_word_valid && last_word) state_d = ST_ACK;
`endif
            ST_ACK:  if (bus.tx_ready) state_d = ST_RUN;
            ST_RUN:  if (bus.start) state_d = ST_HDR;
            ST_ERR:  if (bus.start) state_d = ST_HDR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_count_d = word_count_q;
        len_d        = len_q;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_din_d   = bram_din_q;
        nak_sent_d   = nak_sent_q;
`ifdef INST_LOAD_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        if (restart) begin
            word_count_d = '0;
            nak_sent_d   = 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
            sum_d        = '0;
`endif
        end
        if (state_q == ST_HDR && pk_word_valid) len_d = pk_word[INST_SIZE:0];
        // Length was bounded by CAP in HDR, so word_count cannot pass it and the address never wraps.
        if (state_q == ST_BODY && pk_word_valid) begin
            bram_we_d    = 1'b1;
            bram_addr_d  = word_count_q[INST_SIZE-1:0];
            bram_din_d   = pk_word;
            word_count_d = word_count_q + 1'b1;
`ifdef INST_LOAD_CHECKSUM_EN
            sum_d        = sum_q + pk_word;
`endif
        end
        if (state_q == ST_ERR && bus.tx_ready && !nak_sent_q) nak_sent_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count_q <= '0;
            len_q        <= '0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            nak_sent_q   <= 1'b0;
`ifdef INST_LOAD_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            word_count_q <= word_count_d;
            len_q        <= len_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
            nak_sent_q   <= nak_sent_d;
`ifdef INST_LOAD_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    always_comb begin
        bus.mode     = MODE_STALL;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        case (state_q)
            ST_HDR, ST_BODY,
`ifdef INST_LOAD_CHECKSUM_EN
            ST_SUM,
`endif
            ST_ACK: bus.mode = MODE_LOAD;
            ST_RUN: begin
                bus.mode = MODE_EXEC;
                bus.done = 1'b1;
            end
            ST_ERR: begin
                bus.err      = 1'b1;
                bus.tx_valid = !nak_sent_q;
                bus.tx_data  = NAK_BYTE;
            end
            default: ;
        endcase
        if (state_q == ST_ACK) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = ACK_BYTE;
        end
    end

    assign bus.bram_we    = bram_we_q;
    assign bus.bram_addr  = bram_addr_q;
    assign bus.bram_din   = bram_din_q;
    assign bus.word_count = word_count_q;
    assign bus.state      = state_q;

endmodule
